// File: rtl/stream_sink_if.sv
// stream_sink_if: groups the PE word stream (data_pe/vld_pe/rdy_pe) and the
// host IO bus (write/read strobes, address, data) of stream_sink.
// master = PE plus host side, slave = the sink itself.
interface stream_sink_if #(
  parameter int STREAM_ADDR_L = 10,
  parameter int STREAM_W      = 24
);
  logic [STREAM_W-1:0]      wr_data_io;
  logic [STREAM_ADDR_L-1:0] addr_io;
  logic                     wr_vld_io;
  logic                     rd_vld_io;
  logic [STREAM_W-1:0]      rd_data_io;
  logic                     rd_data_vld_io;
  logic [STREAM_W-1:0]      data_pe;
  logic                     vld_pe;
  logic                     rdy_pe;

  modport master (
    output wr_data_io, addr_io, wr_vld_io, rd_vld_io, data_pe, vld_pe,
    input  rd_data_io, rd_data_vld_io, rdy_pe
  );

  modport slave (
    input  wr_data_io, addr_io, wr_vld_io, rd_vld_io, data_pe, vld_pe,
    output rd_data_io, rd_data_vld_io, rdy_pe
  );
endinterface

// File: rtl/stream_sink.sv
// stream_sink: accepts a vld/rdy word stream from a PE while execution is
// enabled and writes it to consecutive addresses start..end of a private
// single-port memory, then raises done. Outside RUN the host IO port may
// read or write the memory (write wins over read).
// Optional feature: define STREAM_SINK_WORD_CNT_EN to add word_cnt_io, a
// saturating count of accepted PE words since the last rst/reset_execution_io.

// Behavioural single-port memory; rdata is zero unless a read was issued
// LATENCY cycles earlier. slp/sd block any access.
module sp_mem_model #(
  parameter int ADDR_L  = 10,
  parameter int W       = 24,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic              slp,
  input  logic              sd,
  input  logic [ADDR_L-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);
  logic [W-1:0]              mem_r [0:(1<<ADDR_L)-1];
  logic [LATENCY-1:0][W-1:0] pipe_r;
  logic                      access_s;

  assign access_s = ce & ~slp & ~sd;

  // storage array write port
  always_ff @(posedge clk) begin
    if (access_s & we) begin
      mem_r[addr] <= wdata;
    end
  end

  // read data pipeline, zero when no read was issued
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= (access_s & ~we) ? mem_r[addr] : {W{1'b0}};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign rdata = pipe_r[LATENCY-1];
endmodule

module stream_sink #(
  parameter int STREAM_ADDR_L = 10,
  parameter int STREAM_W      = 24,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     slp,
  input  logic                     sd,
  stream_sink_if.slave             bus,
  input  logic                     reset_execution_io,
  input  logic                     enable_execution_io,
  output logic                     done_execution_io,
  input  logic [STREAM_ADDR_L-1:0] stream_start_addr_io,
  input  logic [STREAM_ADDR_L-1:0] stream_end_addr_io
`ifdef STREAM_SINK_WORD_CNT_EN
  ,
  output logic [STREAM_ADDR_L:0]   word_cnt_io
`endif
);
  localparam logic [STREAM_ADDR_L-1:0] PTR_ONE = {{(STREAM_ADDR_L-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  logic [STREAM_ADDR_L-1:0] wr_ptr_r;
  logic                     enable_q;
  logic                     done_r;
  logic [RD_LATENCY-1:0]    rd_pipe_r;

  logic                     io_ok_s;
  logic                     io_wr_s;
  logic                     io_rd_s;
  logic                     pe_wr_s;
  logic                     mem_we_s;
  logic                     mem_ce_s;
  logic [STREAM_ADDR_L-1:0] mem_addr_s;
  logic [STREAM_W-1:0]      mem_wdata_s;
  logic [STREAM_W-1:0]      mem_rdata_s;

  // access arbitration: PE owns the memory in RUN, host IO otherwise
  always_comb begin
    io_ok_s     = (state_r == IDLE) || (state_r == DONE);
    pe_wr_s     = (state_r == RUN) && enable_q && bus.vld_pe && !reset_execution_io && !rst;
    io_wr_s     = io_ok_s && bus.wr_vld_io && !rst;
    io_rd_s     = io_ok_s && bus.rd_vld_io && !bus.wr_vld_io && !rst;
    if (state_r == RUN) begin
      mem_addr_s  = wr_ptr_r;
      mem_wdata_s = bus.data_pe;
    end else begin
      mem_addr_s  = bus.addr_io;
      mem_wdata_s = bus.wr_data_io;
    end
    mem_we_s = pe_wr_s | io_wr_s;
    mem_ce_s = mem_we_s | io_rd_s;
  end

  assign bus.rdy_pe         = (state_r == RUN) && enable_q;
  assign done_execution_io  = done_r;
  assign bus.rd_data_vld_io = rd_pipe_r[RD_LATENCY-1];
  assign bus.rd_data_io     = rd_pipe_r[RD_LATENCY-1] ? mem_rdata_s : {STREAM_W{1'b0}};

  // enable is taken one cycle late, matching the input streams
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable_execution_io;
    end
  end

  // stream FSM: state, write pointer and registered done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      wr_ptr_r <= {STREAM_ADDR_L{1'b0}};
      done_r   <= 1'b0;
    end else if (reset_execution_io) begin
      state_r  <= IDLE;
      wr_ptr_r <= stream_start_addr_io;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable_q) begin
            if (wr_ptr_r <= stream_end_addr_io) begin
              state_r <= RUN;
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!enable_q) begin
            state_r <= IDLE;
          end else if (pe_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (wr_ptr_r == stream_end_addr_io) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= DONE;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // read-valid pipeline; only rst cancels reads in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe_r <= {RD_LATENCY{1'b0}};
    end else begin
      rd_pipe_r[0] <= io_rd_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  // host strobes arriving while the stream owns the memory are discarded
  always_ff @(posedge clk) begin
    if (!rst && (state_r == RUN) && (bus.wr_vld_io || bus.rd_vld_io)) begin
      $warning("stream_sink: IO access during RUN dropped");
    end
  end

`ifdef STREAM_SINK_WORD_CNT_EN
  logic [STREAM_ADDR_L:0] word_cnt_r;

  // saturating count of accepted PE words
  always_ff @(posedge clk) begin
    if (rst || reset_execution_io) begin
      word_cnt_r <= {(STREAM_ADDR_L+1){1'b0}};
    end else if (pe_wr_s && !(&word_cnt_r)) begin
      word_cnt_r <= word_cnt_r + {{STREAM_ADDR_L{1'b0}}, 1'b1};
    end
  end

  assign word_cnt_io = word_cnt_r;
`endif

  sp_mem_model #(
    .ADDR_L  (STREAM_ADDR_L),
    .W       (STREAM_W),
    .LATENCY (RD_LATENCY)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .ce    (mem_ce_s),
    .we    (mem_we_s),
    .slp   (slp),
    .sd    (sd),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
  );
endmodule

// File: tb/tb_stream_sink.sv
// tb_stream_sink: randomized self-checking bench for stream_sink. A memory
// image model predicts contents from the rule "the k-th accepted word lands
// at start+k" and all results are read back through the IO port.
module tb_stream_sink;
  localparam int AL  = 10;
  localparam int W   = 24;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          slp;
  logic          sd;
  logic          reset_execution_io;
  logic          enable_execution_io;
  logic          done_execution_io;
  logic [AL-1:0] stream_start_addr_io;
  logic [AL-1:0] stream_end_addr_io;
`ifdef STREAM_SINK_WORD_CNT_EN
  logic [AL:0]   word_cnt_io;
`endif

  stream_sink_if #(.STREAM_ADDR_L(AL), .STREAM_W(W)) bus ();

  stream_sink #(.STREAM_ADDR_L(AL), .STREAM_W(W), .RD_LATENCY(LAT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slp                  (slp),
    .sd                   (sd),
    .bus                  (bus),
    .reset_execution_io   (reset_execution_io),
    .enable_execution_io  (enable_execution_io),
    .done_execution_io    (done_execution_io),
    .stream_start_addr_io (stream_start_addr_io),
    .stream_end_addr_io   (stream_end_addr_io)
`ifdef STREAM_SINK_WORD_CNT_EN
    ,
    .word_cnt_io          (word_cnt_io)
`endif
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] model_mem [1024];
  logic [W-1:0] tx_q [$];
  int           pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input int a, input logic [W-1:0] d);
    bus.addr_io    = AL'(a);
    bus.wr_data_io = d;
    bus.wr_vld_io  = 1'b1;
    tick();
    bus.wr_vld_io  = 1'b0;
    model_mem[a]   = d;
  endtask

  task automatic io_read(input int a);
    bus.addr_io   = AL'(a);
    bus.rd_vld_io = 1'b1;
    tick();
    bus.rd_vld_io = 1'b0;
    repeat (LAT - 1) tick();
    chk($sformatf("rd_vld@%0d", a), bus.rd_data_vld_io, 1'b1);
    chk($sformatf("rd_data@%0d", a), bus.rd_data_io, model_mem[a]);
    tick();
    chk("rd_idle_vld", bus.rd_data_vld_io, 1'b0);
    chk("rd_idle_data", bus.rd_data_io, 32'd0);
  endtask

  task automatic readback(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) io_read(a);
  endtask

  task automatic program_range(input int s, input int e);
    enable_execution_io  = 1'b0;
    stream_start_addr_io = AL'(s);
    stream_end_addr_io   = AL'(e);
    reset_execution_io   = 1'b1;
    tick();
    reset_execution_io   = 1'b0;
    tick();
  endtask

  task automatic gen_words(input int n);
    tx_q.delete();
    for (int i = 0; i < n + 2; i++) tx_q.push_back(W'($urandom));
  endtask

  task automatic commit(input int s, input int n);
    for (int k = 0; k < n; k++) model_mem[(s + k) % 1024] = tx_q[k];
  endtask

  // PE driver: vld from a percentage (or the fixed pattern when vld_pct<0),
  // optional enable pause, optional reset_execution abort, optional IO poke in RUN
  task automatic fill(input int n_exp, input int vld_pct, input int pause_at, input int pause_len,
                      input int abort_at, input bit io_poke, output int acc, output int first_rdy);
    int cyc, pidx, plen_left, poke_st;
    bit hs, v;
    acc = 0; first_rdy = -1; cyc = 0; pidx = 0; plen_left = 0; poke_st = 0;
    while (cyc < 400 && done_execution_io !== 1'b1) begin
      chk("run_rd_vld", bus.rd_data_vld_io, 1'b0);
      if (bus.rdy_pe === 1'b1 && first_rdy < 0) first_rdy = cyc;
      if (plen_left > 0) begin
        if (plen_left < pause_len) chk("pause_rdy", bus.rdy_pe, 1'b0);
        enable_execution_io = 1'b0;
        v = 1'b0;
        plen_left--;
      end else begin
        enable_execution_io = 1'b1;
        if (vld_pct < 0) v = pat[pidx % 7] != 0;
        else v = ($urandom_range(1, 100) <= vld_pct);
        pidx++;
      end
      bus.vld_pe  = v;
      bus.data_pe = (acc < tx_q.size()) ? tx_q[acc] : '0;
      hs = v && (bus.rdy_pe === 1'b1);
      if (io_poke && poke_st == 0 && bus.rdy_pe === 1'b1) begin
        bus.addr_io = AL'(3); bus.wr_data_io = W'($urandom); bus.wr_vld_io = 1'b1; poke_st = 1;
      end else if (io_poke && poke_st == 1) begin
        bus.addr_io = AL'(3); bus.rd_vld_io = 1'b1; poke_st = 2;
      end
      if (abort_at >= 0 && acc == abort_at && hs) begin
        reset_execution_io  = 1'b1;
        enable_execution_io = 1'b0;
        tick();
        reset_execution_io  = 1'b0;
        bus.vld_pe          = 1'b0;
        return;
      end
      tick();
      bus.wr_vld_io = 1'b0;
      bus.rd_vld_io = 1'b0;
      if (hs) begin
        acc++;
        chk("done_after_acc", done_execution_io, acc == n_exp);
        if (acc == pause_at) plen_left = pause_len;
      end
      cyc++;
    end
    bus.vld_pe = 1'b0;
    chk("fill_done", done_execution_io, 1'b1);
    chk("accepted", acc, n_exp);
    chk("rdy_in_done", bus.rdy_pe, 1'b0);
    chk("post_rd_vld", bus.rd_data_vld_io, 1'b0);
`ifdef STREAM_SINK_WORD_CNT_EN
    chk("word_cnt", word_cnt_io, n_exp);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, fr, s, e, len, vp, pa, pl;
    logic [W-1:0] y;
    rst = 1'b1; slp = 1'b0; sd = 1'b0;
    reset_execution_io = 1'b0; enable_execution_io = 1'b0;
    stream_start_addr_io = '0; stream_end_addr_io = '0;
    bus.wr_data_io = '0; bus.addr_io = '0; bus.wr_vld_io = 1'b0; bus.rd_vld_io = 1'b0;
    bus.data_pe = '0; bus.vld_pe = 1'b0;
    repeat (3) tick();
    chk("rst_rdy", bus.rdy_pe, 1'b0);
    chk("rst_done", done_execution_io, 1'b0);
    chk("rst_rd_vld", bus.rd_data_vld_io, 1'b0);
    chk("rst_rd_data", bus.rd_data_io, 32'd0);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) io_write(a, W'($urandom));
    for (int a = 1016; a < 1024; a++) io_write(a, W'($urandom));

    // basic fill of 4..7 with vld held high
    program_range(4, 7);
    tx_q = '{24'h000011, 24'h000022, 24'h000033, 24'h000044, 24'h000055};
    fill(4, 100, -1, 0, -1, 1'b0, acc, fr);
    chk("basic_first_rdy", fr, 2);
    commit(4, 4);
    readback(3, 8);

    // gapped vld pattern
    program_range(4, 7);
    gen_words(4);
    fill(4, -1, -1, 0, -1, 1'b0, acc, fr);
    commit(4, 4);
    readback(3, 8);

    // pause after two accepts
    program_range(4, 7);
    gen_words(4);
    fill(4, 100, 2, 3, -1, 1'b0, acc, fr);
    commit(4, 4);
    readback(3, 8);

    // empty range: done without writes
    program_range(5, 4);
    gen_words(2);
    fill(0, 100, -1, 0, -1, 1'b0, acc, fr);
    readback(3, 8);

    // range ending at the top address
    program_range(1022, 1023);
    gen_words(2);
    fill(2, 100, -1, 0, -1, 1'b0, acc, fr);
    commit(1022, 2);
    readback(1020, 1023);

    // IO strobes during RUN are dropped; write beats read in DONE
    program_range(8, 11);
    gen_words(4);
    fill(4, 70, -1, 0, -1, 1'b1, acc, fr);
    commit(8, 4);
    readback(3, 3);
    y = W'($urandom);
    bus.addr_io = AL'(3); bus.wr_data_io = y; bus.wr_vld_io = 1'b1; bus.rd_vld_io = 1'b1;
    tick();
    bus.wr_vld_io = 1'b0; bus.rd_vld_io = 1'b0;
    model_mem[3] = y;
    for (int i = 0; i <= LAT; i++) begin
      chk("dual_rd_vld", bus.rd_data_vld_io, 1'b0);
      tick();
    end
    readback(3, 3);

    // reset_execution mid-RUN with a handshake in the same cycle
    program_range(4, 7);
    gen_words(4);
    fill(4, 100, -1, 0, 2, 1'b0, acc, fr);
    chk("abort_done", done_execution_io, 1'b0);
    chk("abort_rdy", bus.rdy_pe, 1'b0);
`ifdef STREAM_SINK_WORD_CNT_EN
    chk("abort_word_cnt", word_cnt_io, 32'd0);
`endif
    commit(4, 2);
    readback(3, 8);
    gen_words(4);
    fill(4, 100, -1, 0, -1, 1'b0, acc, fr);
    chk("resume_first_rdy", fr, 2);
    commit(4, 4);
    readback(3, 8);

    // randomized ranges, vld density and pauses
    for (int it = 0; it < 6; it++) begin
      s   = $urandom_range(16, 990);
      len = $urandom_range(1, 24);
      e   = s + len - 1;
      program_range(s, e);
      for (int a = s - 1; a <= e + 1; a++) io_write(a, W'($urandom));
      gen_words(len);
      vp = $urandom_range(30, 100);
      pa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len) : -1;
      pl = $urandom_range(1, 4);
      fill(len, vp, pa, pl, -1, 1'b0, acc, fr);
      commit(s, len);
      readback(s - 1, e + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
